// File: rtl/main_memory_responder_pkg.sv
// ------------------------------------------------------------------
// main_memory_responder_pkg: shared constants, state encoding, helpers
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package main_memory_responder_pkg;

   localparam int DEF_MEMORY_ADDRESS_SIZE = 32;
   localparam int DEF_CACHE_LINE_SIZE     = 128;
   localparam int DEF_MEMORY_LATENCY      = 5;
   localparam int DEF_MEMORY_DEPTH_LINES  = 4096;
   localparam int LATENCY_COUNTER_BITS    = 8;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_BUSY = 2'd1,
      MEM_DONE = 2'd2
   } mem_state_t;

   function automatic int line_offset_bits(input int line_size_bits);
      return $clog2(line_size_bits / 8);
   endfunction

endpackage

`default_nettype wire

// File: rtl/main_memory_responder_line_array.sv
// ------------------------------------------------------------------
// memory_line_array: single-port line storage with registered read data
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module memory_line_array #(
   parameter int    LINE_BITS  = 128,
   parameter int    DEPTH      = 4096,
   parameter int    INDEX_BITS = 12,
   parameter string INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  write_enable,
   input  logic [INDEX_BITS-1:0] index,
   input  logic [LINE_BITS-1:0]  write_data,
   output logic [LINE_BITS-1:0]  read_data
);

   logic [LINE_BITS-1:0] lines [DEPTH];

   // Contents are never cleared by reset.
   always_ff @(posedge clk) begin
      if (write_enable) begin
         lines[index] <= write_data;
      end
      read_data <= lines[index];
   end

endmodule

`default_nettype wire

// File: rtl/main_memory_responder.sv
// ------------------------------------------------------------------
// main_memory_responder: fixed-latency line-granular main-memory responder
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module main_memory_responder
   import main_memory_responder_pkg::*;
#(
   parameter int    MEMORY_ADDRESS_SIZE = DEF_MEMORY_ADDRESS_SIZE,
   parameter int    CACHE_LINE_SIZE     = DEF_CACHE_LINE_SIZE,
   parameter int    MEMORY_LATENCY      = DEF_MEMORY_LATENCY,
   parameter int    MEMORY_DEPTH_LINES  = DEF_MEMORY_DEPTH_LINES,
   parameter string INIT_FILE           = ""
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           mem_enable,
   input  logic                           mem_op,
   input  logic [MEMORY_ADDRESS_SIZE-1:0] mem_address,
   input  logic [CACHE_LINE_SIZE-1:0]     mem_data_in,
   output logic                           mem_data_ready,
   output logic [CACHE_LINE_SIZE-1:0]     mem_data_out,
   output logic                           busy
);

   localparam int LINE_OFFSET_BITS = line_offset_bits(CACHE_LINE_SIZE);
   localparam int LINE_INDEX_BITS  = $clog2(MEMORY_DEPTH_LINES);
   localparam logic [LATENCY_COUNTER_BITS-1:0] COUNT_RELOAD =
      LATENCY_COUNTER_BITS'(MEMORY_LATENCY - 1);

   mem_state_t                      state, state_next;
   logic [LATENCY_COUNTER_BITS-1:0] counter, counter_next;
   logic                            accept, complete;
   logic                            op_q;
   logic [LINE_INDEX_BITS-1:0]      index_q, address_index, array_index;
   logic [CACHE_LINE_SIZE-1:0]      data_q, array_read_data;
   logic                            unused_address;

   assign address_index  = mem_address[LINE_OFFSET_BITS +: LINE_INDEX_BITS];
   assign unused_address = ^mem_address;
   assign busy           = (state != MEM_IDLE);

   // In IDLE the array reads the incoming line so its registered output is
   // already valid at the completion edge, even with a one-cycle latency.
   assign array_index = (state == MEM_IDLE) ? address_index : index_q;

   always_comb begin
      state_next   = state;
      counter_next = counter;
      accept       = 1'b0;
      complete     = 1'b0;
      case (state)
         MEM_IDLE: begin
            if (mem_enable) begin
               accept       = 1'b1;
               counter_next = COUNT_RELOAD;
               state_next   = MEM_BUSY;
            end
         end
         MEM_BUSY: begin
            if (!mem_enable) begin
               counter_next = '0;
               state_next   = MEM_IDLE;
            end else if (counter != '0) begin
               counter_next = counter - 1'b1;
            end else begin
               complete   = 1'b1;
               state_next = MEM_DONE;
            end
         end
         MEM_DONE: begin
            if (!mem_enable) begin
               state_next = MEM_IDLE;
            end
         end
         default: begin
            counter_next = '0;
            state_next   = MEM_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= MEM_IDLE;
         counter        <= '0;
         op_q           <= 1'b0;
         index_q        <= '0;
         data_q         <= '0;
         mem_data_ready <= 1'b0;
         mem_data_out   <= '0;
      end else begin
         state   <= state_next;
         counter <= counter_next;
         if (accept) begin
            op_q    <= mem_op;
            index_q <= address_index;
            data_q  <= mem_data_in;
         end
         if (complete) begin
            mem_data_ready <= 1'b1;
            mem_data_out   <= op_q ? data_q : array_read_data;
         end else if (state == MEM_DONE && !mem_enable) begin
            mem_data_ready <= 1'b0;
         end
      end
   end

   memory_line_array #(
      .LINE_BITS  (CACHE_LINE_SIZE),
      .DEPTH      (MEMORY_DEPTH_LINES),
      .INDEX_BITS (LINE_INDEX_BITS),
      .INIT_FILE  (INIT_FILE)
   ) u_line_array (
      .clk          (clk),
      .write_enable (complete & op_q),
      .index        (array_index),
      .write_data   (data_q),
      .read_data    (array_read_data)
   );

endmodule

`default_nettype wire

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: a latency-5 and a latency-1 instance checked
// every cycle against a transaction-level line model.
`default_nettype none

module tb_main_memory_responder;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         en     [2];
   logic         op     [2];
   logic [31:0]  addr   [2];
   logic [127:0] wdata  [2];
   logic         ready  [2];
   logic [127:0] dout   [2];
   logic         busy_o [2];

   logic         exp_ready [2];
   logic         exp_busy  [2];
   logic [127:0] exp_data  [2];

   logic [127:0] mdl0 [int];
   logic [127:0] mdl1 [int];
   int           lat  [2];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   main_memory_responder #(.MEMORY_LATENCY(5)) u_dut_a (
      .clk(clk), .reset(reset), .mem_enable(en[0]), .mem_op(op[0]),
      .mem_address(addr[0]), .mem_data_in(wdata[0]), .mem_data_ready(ready[0]),
      .mem_data_out(dout[0]), .busy(busy_o[0])
   );

   main_memory_responder #(.MEMORY_LATENCY(1)) u_dut_b (
      .clk(clk), .reset(reset), .mem_enable(en[1]), .mem_op(op[1]),
      .mem_address(addr[1]), .mem_data_in(wdata[1]), .mem_data_ready(ready[1]),
      .mem_data_out(dout[1]), .busy(busy_o[1])
   );

   function automatic void check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   // 16-byte lines, 4096 lines deep
   function automatic int line_of(input logic [31:0] a);
      return int'((a >> 4) % 32'd4096);
   endfunction

   always @(negedge clk) begin
      for (int w = 0; w < 2; w++) begin
         check($sformatf("busy%0d", w), {127'd0, busy_o[w]}, {127'd0, exp_busy[w]});
         check($sformatf("ready%0d", w), {127'd0, ready[w]}, {127'd0, exp_ready[w]});
         check($sformatf("data%0d", w), dout[w], exp_data[w]);
      end
   end

   task automatic scramble(input int w);
      op[w]    = 1'($urandom);
      addr[w]  = $urandom;
      wdata[w] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #1;
      for (int w = 0; w < 2; w++) begin
         en[w]        = 1'b0;
         exp_ready[w] = 1'b0;
         exp_busy[w]  = 1'b0;
         exp_data[w]  = '0;
      end
   endtask

   // One full request; optional extra held cycles after ready, optional reset in DONE.
   task automatic txn(input int w, input bit wr, input logic [31:0] a, input logic [127:0] d,
                      input int hold, input bit rst_in_done, output logic [127:0] got);
      logic [127:0] res;
      int           i;
      en[w] = 1'b1; op[w] = wr; addr[w] = a; wdata[w] = d;
      @(posedge clk); #1;
      exp_busy[w] = 1'b1; exp_ready[w] = 1'b0;
      scramble(w);
      for (int j = 1; j < lat[w]; j++) begin
         @(posedge clk); #1;
         scramble(w);
      end
      @(posedge clk); #1;
      i = line_of(a);
      if (wr) begin
         res = d;
         if (w == 0) mdl0[i] = d; else mdl1[i] = d;
      end else begin
         res = (w == 0) ? mdl0[i] : mdl1[i];
      end
      exp_ready[w] = 1'b1;
      exp_data[w]  = res;
      got = dout[w];
      if (rst_in_done) begin
         apply_reset();
         check("rst_done_ready", {127'd0, ready[w]}, 128'd0);
         check("rst_done_data", dout[w], 128'd0);
         @(posedge clk); #1;
         reset = 1'b0;
         return;
      end
      repeat (hold) begin
         @(posedge clk); #1;
         scramble(w);
      end
      en[w] = 1'b0;
      @(posedge clk); #1;
      exp_ready[w] = 1'b0;
      exp_busy[w]  = 1'b0;
   endtask

   // Write that is cut short in its second BUSY cycle by enable drop or reset.
   task automatic abort_write(input logic [31:0] a, input logic [127:0] d, input bit use_reset);
      en[0] = 1'b1; op[0] = 1'b1; addr[0] = a; wdata[0] = d;
      @(posedge clk); #1;
      exp_busy[0] = 1'b1; exp_ready[0] = 1'b0;
      @(posedge clk); #1;
      if (use_reset) begin
         apply_reset();
         check("rst_busy_busy", {127'd0, busy_o[0]}, 128'd0);
         check("rst_busy_data", dout[0], 128'd0);
         @(posedge clk); #1;
         reset = 1'b0;
      end else begin
         en[0] = 1'b0;
         @(posedge clk); #1;
         exp_busy[0] = 1'b0;
      end
   endtask

   initial begin
      logic [127:0] got, a5, v8, v9, d2, ffs;
      logic [31:0]  wa [$];
      lat[0] = 5; lat[1] = 1;
      for (int w = 0; w < 2; w++) begin
         en[w] = 1'b0; op[w] = 1'b0; addr[w] = '0; wdata[w] = '0;
         exp_ready[w] = 1'b0; exp_busy[w] = 1'b0; exp_data[w] = '0;
      end
      a5  = {16{8'hA5}};
      ffs = '1;
      #2;
      check("reset_ready", {127'd0, ready[0]}, 128'd0);
      check("reset_data", dout[0], 128'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      txn(0, 1'b1, 32'h0000_0040, a5, 0, 1'b0, got);
      check("wr40_echo", got, a5);
      txn(0, 1'b0, 32'h0000_0040, '0, 3, 1'b0, got);
      check("rd40", got, a5);
      txn(0, 1'b0, 32'h0000_0044, '0, 0, 1'b0, got);
      check("rd44_offset", got, a5);
      txn(0, 1'b0, 32'h0001_0040, '0, 1, 1'b0, got);
      check("rd10040_alias", got, a5);

      v8 = {$urandom, $urandom, $urandom, $urandom};
      txn(0, 1'b1, 32'h0000_0080, v8, 0, 1'b0, got);
      abort_write(32'h0000_0080, ffs, 1'b0);
      txn(0, 1'b0, 32'h0000_0080, '0, 0, 1'b0, got);
      check("rd80_after_abort", got, v8);

      v9 = {$urandom, $urandom, $urandom, $urandom};
      d2 = {$urandom, $urandom, $urandom, $urandom};
      txn(0, 1'b1, 32'h0000_0090, v9, 0, 1'b0, got);
      abort_write(32'h0000_0090, ffs, 1'b1);
      txn(0, 1'b0, 32'h0000_0090, '0, 0, 1'b0, got);
      check("rd90_after_rst_busy", got, v9);
      txn(0, 1'b1, 32'h0000_0090, d2, 0, 1'b1, got);
      txn(0, 1'b0, 32'h0000_0090, '0, 0, 1'b0, got);
      check("rd90_after_rst_done", got, d2);

      wa.push_back(32'h0000_0040); wa.push_back(32'h0000_0080); wa.push_back(32'h0000_0090);
      for (int k = 0; k < 24; k++) begin
         logic [31:0] a;
         if ($urandom_range(1) == 1) begin
            a = $urandom;
            wa.push_back(a);
            txn(0, 1'b1, a, {$urandom, $urandom, $urandom, $urandom},
                int'($urandom_range(3)), 1'b0, got);
         end else begin
            a = wa[$urandom_range(wa.size() - 1)] ^ 32'($urandom_range(15));
            txn(0, 1'b0, a, '0, int'($urandom_range(3)), 1'b0, got);
         end
      end

      for (int k = 0; k < 16; k++) begin
         logic [31:0]  a;
         logic [127:0] d;
         a = $urandom;
         d = {$urandom, $urandom, $urandom, $urandom};
         txn(1, 1'b1, a, d, int'($urandom_range(2)), 1'b0, got);
         txn(1, 1'b0, a ^ 32'($urandom_range(15)), '0, int'($urandom_range(2)), 1'b0, got);
         check("lat1_rd", got, d);
      end

      repeat (2) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
